// File: rtl/maxnet_scheduler.sv
// maxnet_scheduler: time-shares one 4-input PU across a 4-neuron Maxnet, iterating
// until at most one activation survives or the iteration limit is reached.
module maxnet_scheduler #(
    parameter logic [31:0] SELF_W   = 32'h3F800000,
    parameter logic [31:0] EPS_W    = 32'hBE4CCCCD,
    parameter int          MAX_ITER = 16,
    parameter int          ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       x_in0,
    input  logic [31:0]       x_in1,
    input  logic [31:0]       x_in2,
    input  logic [31:0]       x_in3,
    output logic [31:0]       pu_x0,
    output logic [31:0]       pu_x1,
    output logic [31:0]       pu_x2,
    output logic [31:0]       pu_x3,
    output logic [31:0]       pu_w0,
    output logic [31:0]       pu_w1,
    output logic [31:0]       pu_w2,
    output logic [31:0]       pu_w3,
    output logic              mult_reg_en,
    output logic              add_reg_en,
    input  logic [31:0]       new_value,
    input  logic              zero_signal,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner_idx,
    output logic [31:0]       winner_value,
    output logic              no_winner,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    typedef enum logic [2:0] {IDLE, MULT, ADD, CAP, UPDATE, DONE} state_t;

    state_t           state, state_nx;
    logic [1:0]       j;
    logic [3:0][31:0] x, nx;
    logic [3:0]       nz;
    logic [2:0]       n;
    logic [1:0]       nz_idx;
    logic             last_iter;
    logic             start_ok;

    assign n         = 3'(nz[0]) + 3'(nz[1]) + 3'(nz[2]) + 3'(nz[3]);
    assign nz_idx    = nz[3] ? 2'd3 : nz[2] ? 2'd2 : nz[1] ? 2'd1 : 2'd0;
    assign last_iter = iter_count == ITER_W'(MAX_ITER - 1);
    assign start_ok  = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? MULT : state;
            MULT:       state_nx = ADD;
            ADD:        state_nx = CAP;
            CAP:        state_nx = (j == 2'd3) ? UPDATE : MULT;
            UPDATE:     state_nx = (n <= 3'd1 || last_iter) ? DONE : MULT;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            j            <= '0;
            x            <= '0;
            nx           <= '0;
            nz           <= '0;
            iter_count   <= '0;
            winner_idx   <= '0;
            winner_value <= '0;
            no_winner    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                x            <= {x_in3, x_in2, x_in1, x_in0};
                j            <= '0;
                iter_count   <= '0;
                winner_idx   <= '0;
                winner_value <= '0;
                no_winner    <= 1'b0;
                timeout      <= 1'b0;
            end
            if (state == CAP) begin
                nx[j] <= new_value;
                nz[j] <= ~zero_signal;
                j     <= j + 2'd1;
            end
            // Activations advance together so every neuron in an iteration sees the same x
            if (state == UPDATE) begin
                x          <= nx;
                iter_count <= iter_count + ITER_W'(1);
                j          <= '0;
                if (state_nx == DONE) begin
                    no_winner    <= n == 3'd0;
                    timeout      <= n >= 3'd2;
                    winner_idx   <= (n == 3'd1) ? nz_idx : 2'd0;
                    winner_value <= (n == 3'd1) ? nx[nz_idx] : 32'd0;
                end
            end
        end
    end

    assign pu_x0       = x[0];
    assign pu_x1       = x[1];
    assign pu_x2       = x[2];
    assign pu_x3       = x[3];
    assign pu_w0       = (state != MULT) ? 32'd0 : (j == 2'd0) ? SELF_W : EPS_W;
    assign pu_w1       = (state != MULT) ? 32'd0 : (j == 2'd1) ? SELF_W : EPS_W;
    assign pu_w2       = (state != MULT) ? 32'd0 : (j == 2'd2) ? SELF_W : EPS_W;
    assign pu_w3       = (state != MULT) ? 32'd0 : (j == 2'd3) ? SELF_W : EPS_W;
    assign mult_reg_en = state == MULT;
    assign add_reg_en  = state == ADD;
    assign busy        = state inside {MULT, ADD, CAP, UPDATE};
    assign done        = state == DONE;
endmodule

// File: tb/tb_maxnet_scheduler.sv
// tb_maxnet_scheduler: directed vectors against a scripted PU that replays
// hand-computed AF outputs, plus restart, ignored-start and mid-run reset sequences.
module tb_maxnet_scheduler;
    localparam logic [31:0] SELF_W = 32'h3F800000;
    localparam logic [31:0] EPS_W  = 32'hBE4CCCCD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x_in0 = '0, x_in1 = '0, x_in2 = '0, x_in3 = '0;
    logic [31:0] pu_x0, pu_x1, pu_x2, pu_x3, pu_w0, pu_w1, pu_w2, pu_w3;
    logic        mult_reg_en, add_reg_en, busy, done, no_winner, timeout;
    logic [31:0] new_value = '0;
    logic        zero_signal = 1'b1;
    logic [1:0]  winner_idx;
    logic [31:0] winner_value;
    logic [4:0]  iter_count;

    maxnet_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in0(x_in0), .x_in1(x_in1), .x_in2(x_in2), .x_in3(x_in3),
        .pu_x0(pu_x0), .pu_x1(pu_x1), .pu_x2(pu_x2), .pu_x3(pu_x3),
        .pu_w0(pu_w0), .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3),
        .mult_reg_en(mult_reg_en), .add_reg_en(add_reg_en),
        .new_value(new_value), .zero_signal(zero_signal),
        .busy(busy), .done(done), .winner_idx(winner_idx), .winner_value(winner_value),
        .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    logic [31:0] px [4];
    logic [31:0] pw [4];
    assign px[0] = pu_x0;
    assign px[1] = pu_x1;
    assign px[2] = pu_x2;
    assign px[3] = pu_x3;
    assign pw[0] = pu_w0;
    assign pw[1] = pu_w1;
    assign pw[2] = pu_w2;
    assign pw[3] = pu_w3;

    typedef struct {
        logic [3:0][31:0]  x;
        logic [15:0][31:0] resp;
        int                iters;
        logic [1:0]        widx;
        logic [31:0]       wval;
        logic              nw;
        logic              to;
        logic              poke;
    } vec_t;

    vec_t             vecs [5];
    logic [15:0][31:0] cur_resp = '0;
    int               pcnt = 0;
    int               n_chk = 0;
    int               n_bad = 0;

    // Scripted PU: presents the next AF output once the sum register is loaded;
    // past the script it keeps replaying the last iteration's row.
    always @(negedge clk) begin
        if (rst || (start && !busy)) begin
            pcnt = 0;
        end else if (add_reg_en) begin
            new_value   = cur_resp[(pcnt < 16) ? pcnt : 12 + pcnt % 4];
            zero_signal = new_value == 32'd0;
            pcnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int  c;
        int  ph;
        int  nj;
        bit  em, ea, ok;
        cur_resp = v.resp;
        {x_in3, x_in2, x_in1, x_in0} = v.x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d restart_clears", id),
            {27'd0, done, no_winner, timeout, |winner_value, |iter_count}, 32'd0);
        c  = 0;
        ok = 1'b1;
        while (!done && c < 400) begin
            ph = c % 13;
            nj = ph / 3;
            em = (ph < 12) && (ph % 3 == 0);
            ea = (ph < 12) && (ph % 3 == 1);
            if (mult_reg_en !== em || add_reg_en !== ea || busy !== 1'b1) ok = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (em && pw[k] !== ((k == nj) ? SELF_W : EPS_W)) ok = 1'b0;
                if (c < 13 && px[k] !== v.x[k]) ok = 1'b0;
                if (c >= 13 && c < 26 && px[k] !== v.resp[k]) ok = 1'b0;
            end
            if (v.poke && c == 3) begin
                start = 1'b1;
                {x_in3, x_in2, x_in1, x_in0} = {4{32'h40400000}};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        chk($sformatf("v%0d pu_pattern", id), 32'(ok), 32'd1);
        chk($sformatf("v%0d done_latency", id), 32'(c), 32'(13 * v.iters));
        chk($sformatf("v%0d iter_count", id), 32'(iter_count), 32'(v.iters));
        chk($sformatf("v%0d winner_idx", id), 32'(winner_idx), 32'(v.widx));
        chk($sformatf("v%0d winner_value", id), winner_value, v.wval);
        chk($sformatf("v%0d no_winner", id), 32'(no_winner), 32'(v.nw));
        chk($sformatf("v%0d timeout", id), 32'(timeout), 32'(v.to));
        chk($sformatf("v%0d busy_in_done", id), 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {31'd0, |{pu_x0, pu_x1, pu_x2, pu_x3, pu_w0, pu_w1, pu_w2, pu_w3,
                         mult_reg_en, add_reg_en, busy, done, winner_idx, winner_value,
                         no_winner, timeout, iter_count}};
    endfunction

    initial begin
        foreach (vecs[i]) begin
            vecs[i].resp = '0;
            vecs[i].poke = 1'b0;
            vecs[i].nw   = 1'b0;
            vecs[i].to   = 1'b0;
            vecs[i].widx = 2'd0;
            vecs[i].wval = 32'd0;
        end
        // lone 1.0 on neuron 2
        vecs[0].x         = {32'h0, 32'h3F800000, 32'h0, 32'h0};
        vecs[0].resp[3:0] = {32'h0, 32'h3F800000, 32'h0, 32'h0};
        vecs[0].iters     = 1;
        vecs[0].widx      = 2'd2;
        vecs[0].wval      = 32'h3F800000;
        // all zero
        vecs[1].x         = '0;
        vecs[1].iters     = 1;
        vecs[1].nw        = 1'b1;
        // 1.0, 0.5: 0.9/0.3 -> 0.84/0.12 -> 0.816/0; stray start during iteration 1
        vecs[2].x          = {32'h0, 32'h0, 32'h3F000000, 32'h3F800000};
        vecs[2].resp[3:0]  = {32'h0, 32'h0, 32'h3E99999A, 32'h3F666666};
        vecs[2].resp[7:4]  = {32'h0, 32'h0, 32'h3DF5C28F, 32'h3F570A3D};
        vecs[2].resp[11:8] = {32'h0, 32'h0, 32'h0, 32'h3F50E560};
        vecs[2].iters      = 3;
        vecs[2].wval       = 32'h3F50E560;
        vecs[2].poke       = 1'b1;
        // mirrored: winner lands on neuron 3
        vecs[3].x          = {32'h3F800000, 32'h0, 32'h0, 32'h3F000000};
        vecs[3].resp[3:0]  = {32'h3F666666, 32'h0, 32'h0, 32'h3E99999A};
        vecs[3].resp[7:4]  = {32'h3F570A3D, 32'h0, 32'h0, 32'h3DF5C28F};
        vecs[3].resp[11:8] = {32'h3F50E560, 32'h0, 32'h0, 32'h0};
        vecs[3].iters      = 3;
        vecs[3].widx       = 2'd3;
        vecs[3].wval       = 32'h3F50E560;
        // symmetric input never resolves: 0.4, 0.16, 0.064, 0.0256 ... until the limit
        vecs[4].x           = {4{32'h3F800000}};
        vecs[4].resp[3:0]   = {4{32'h3ECCCCCD}};
        vecs[4].resp[7:4]   = {4{32'h3E23D70A}};
        vecs[4].resp[11:8]  = {4{32'h3D83126F}};
        vecs[4].resp[15:12] = {4{32'h3CD1B717}};
        vecs[4].iters       = 16;
        vecs[4].to          = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", all_outs(), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 5; i++) run(vecs[i], i);

        // reset in the middle of ADD for neuron 0
        {x_in3, x_in2, x_in1, x_in0} = vecs[2].x;
        cur_resp = vecs[2].resp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_in_add", 32'(add_reg_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outputs_zero", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_rst_idle", {30'd0, busy, done}, 32'd0);

        run(vecs[0], 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
